lcd_timing_gen: RTL and testbench

- Parametrised RGB LCD timing generator; successor to the fixed-table, ID-selected LCD driver.
- Timing is loaded at run time through a config strobe and held in shadow registers. New timing takes effect only at a frame boundary.
- Generates real HS/VS with programmable polarity and registered DE/RGB outputs.
- Requests pixels a parametrised number of cycles ahead, so upstream pipelines (char ROM, SDRAM FIFO) can be used.

---
 rtl/lcd_timing_gen.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator with run-time timing shadow registers,
// programmable sync polarity and a lead-time pixel request port.
module lcd_timing_gen #(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 11,
  parameter int REQ_LEAD = 1,
  parameter int DEF_HS   = 41,
  parameter int DEF_HB   = 2,
  parameter int DEF_HD   = 480,
  parameter int DEF_HF   = 2,
  parameter int DEF_VS   = 10,
  parameter int DEF_VB   = 2,
  parameter int DEF_VD   = 272,
  parameter int DEF_VF   = 2,
  parameter bit DEF_HPOL = 1'b0,
  parameter bit DEF_VPOL = 1'b0
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_hs,
  input  logic [CNT_W-1:0]  cfg_hb,
  input  logic [CNT_W-1:0]  cfg_hd,
  input  logic [CNT_W-1:0]  cfg_hf,
  input  logic [CNT_W-1:0]  cfg_vs,
  input  logic [CNT_W-1:0]  cfg_vb,
  input  logic [CNT_W-1:0]  cfg_vd,
  input  logic [CNT_W-1:0]  cfg_vf,
  input  logic              cfg_hpol,
  input  logic              cfg_vpol,
  output logic              cfg_pending,
  output logic              cfg_err,
  input  logic              bl_en,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              data_req,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic [CNT_W-1:0]  h_disp,
  output logic [CNT_W-1:0]  v_disp,
  output logic              frame_start,
  output logic              lcd_de,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              lcd_clk,
  output logic              lcd_bl,
  output logic              lcd_rst
);

  localparam int XW = CNT_W + 2;
  localparam logic [XW-1:0] MAX_T = XW'((2 ** CNT_W) - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] hs;
    logic [CNT_W-1:0] hd;
    logic [CNT_W-1:0] htot;
    logic [CNT_W-1:0] hst;
    logic [CNT_W-1:0] hend;
    logic [CNT_W-1:0] reqs;
    logic [CNT_W-1:0] reqe;
    logic [CNT_W-1:0] vs;
    logic [CNT_W-1:0] vd;
    logic [CNT_W-1:0] vtot;
    logic [CNT_W-1:0] vst;
    logic [CNT_W-1:0] vend;
    logic             hpol;
    logic             vpol;
  } tim_t;

  function automatic tim_t mk_tim(
    input logic [CNT_W-1:0] hs, hb, hd, hf,
    input logic [CNT_W-1:0] vs, vb, vd, vf,
    input logic             hp, vp
  );
    logic [XW-1:0] hst;
    logic [XW-1:0] vst;
    tim_t t;
    hst = XW'(hs) + XW'(hb);
    vst = XW'(vs) + XW'(vb);
    t.hs   = hs;
    t.hd   = hd;
    t.hst  = CNT_W'(hst);
    t.hend = CNT_W'(hst + XW'(hd));
    t.htot = CNT_W'(hst + XW'(hd) + XW'(hf));
    t.reqs = CNT_W'(hst - XW'(REQ_LEAD));
    t.reqe = CNT_W'(hst + XW'(hd) - XW'(REQ_LEAD));
    t.vs   = vs;
    t.vd   = vd;
    t.vst  = CNT_W'(vst);
    t.vend = CNT_W'(vst + XW'(vd));
    t.vtot = CNT_W'(vst + XW'(vd) + XW'(vf));
    t.hpol = hp;
    t.vpol = vp;
    return t;
  endfunction

  localparam tim_t DEF_T = mk_tim(
    CNT_W'(DEF_HS), CNT_W'(DEF_HB), CNT_W'(DEF_HD), CNT_W'(DEF_HF),
    CNT_W'(DEF_VS), CNT_W'(DEF_VB), CNT_W'(DEF_VD), CNT_W'(DEF_VF),
    DEF_HPOL, DEF_VPOL);

  tim_t act_q, act_d, pend_q, pend_d, cfg_t;
  logic pend_v_q, pend_v_d, err_q, err_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic de_q, hs_q, vs_q, fs_q, rst_q, bl_q;
  logic [DATA_W-1:0] rgb_q, pix_q;

  logic [XW-1:0] hst_x, htot_x, vtot_x;
  logic cfg_ok, line_end, frame_end;
  logic h_act, v_act, de_n, hs_n, vs_n;

  assign hst_x  = XW'(cfg_hs) + XW'(cfg_hb);
  assign htot_x = hst_x + XW'(cfg_hd) + XW'(cfg_hf);
  assign vtot_x = XW'(cfg_vs) + XW'(cfg_vb) + XW'(cfg_vd) + XW'(cfg_vf);

  assign cfg_ok = (cfg_hd != '0) && (cfg_vd != '0) &&
                  (cfg_hs != '0) && (cfg_vs != '0) &&
                  (htot_x <= MAX_T) && (vtot_x <= MAX_T) &&
                  (hst_x >= XW'(REQ_LEAD));

  assign cfg_t = mk_tim(cfg_hs, cfg_hb, cfg_hd, cfg_hf,
                        cfg_vs, cfg_vb, cfg_vd, cfg_vf,
                        cfg_hpol, cfg_vpol);

  assign line_end  = (h_q == act_q.htot - ONE);
  assign frame_end = line_end && (v_q == act_q.vtot - ONE);

  assign h_act = (h_q >= act_q.hst) && (h_q < act_q.hend);
  assign v_act = (v_q >= act_q.vst) && (v_q < act_q.vend);
  assign de_n  = h_act && v_act;
  assign hs_n  = (h_q < act_q.hs);
  assign vs_n  = (v_q < act_q.vs);

  assign data_req = v_act && (h_q >= act_q.reqs) && (h_q < act_q.reqe);
  assign pixel_xpos = data_req ? h_q - act_q.reqs : '0;
  assign pixel_ypos = data_req ? v_q - act_q.vst : '0;

  always_comb begin
    act_d    = act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    err_d    = 1'b0;
    h_d      = h_q + ONE;
    v_d      = v_q;
    if (line_end) begin
      h_d = '0;
      v_d = frame_end ? '0 : v_q + ONE;
    end
    if (frame_end && pend_v_q) begin
      act_d    = pend_q;
      pend_v_d = 1'b0;
    end
    if (cfg_valid) begin
      if (cfg_ok) begin
        pend_d   = cfg_t;
        pend_v_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // pix_q realigns data returned REQ_LEAD-1 cycles after the request with de_n
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      act_q    <= DEF_T;
      pend_q   <= DEF_T;
      pend_v_q <= 1'b0;
      err_q    <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~DEF_HPOL;
      vs_q     <= ~DEF_VPOL;
      rgb_q    <= '0;
      pix_q    <= '0;
      fs_q     <= 1'b0;
      rst_q    <= 1'b0;
      bl_q     <= 1'b0;
    end else begin
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      err_q    <= err_d;
      h_q      <= h_d;
      v_q      <= v_d;
      de_q     <= de_n;
      hs_q     <= hs_n ? act_q.hpol : ~act_q.hpol;
      vs_q     <= vs_n ? act_q.vpol : ~act_q.vpol;
      rgb_q    <= de_n ? pix_q : '0;
      pix_q    <= pixel_data;
      fs_q     <= (h_q == '0) && (v_q == '0);
      rst_q    <= 1'b1;
      bl_q     <= bl_en;
    end
  end

  assign cfg_pending = pend_v_q;
  assign cfg_err     = err_q;
  assign h_disp      = act_q.hd;
  assign v_disp      = act_q.vd;
  assign frame_start = fs_q;
  assign lcd_de      = de_q;
  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_rgb     = rgb_q;
  assign lcd_clk     = lcd_pclk;
  assign lcd_bl      = bl_q;
  assign lcd_rst     = rst_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: 480x272 defaults on one instance,
// run-time timing load, rejection and collision on a small instance.
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        bl_en;
  logic        cfg_valid;
  logic        cfg_valid0;
  logic [10:0] cfg_hs, cfg_hb, cfg_hd, cfg_hf;
  logic [10:0] cfg_vs, cfg_vb, cfg_vd, cfg_vf;
  logic        cfg_hpol, cfg_vpol;
  logic [15:0] pix, pix0;

  logic        d_pend, d_err, d_req, d_fs, d_de, d_hs, d_vs;
  logic        d_clk, d_bl, d_rst;
  logic [10:0] d_x, d_y, d_hdisp, d_vdisp;
  logic [15:0] d_rgb;

  logic        s_pend, s_err, s_req, s_fs, s_de, s_hs, s_vs;
  logic        s_clk, s_bl, s_rst;
  logic [10:0] s_x, s_y, s_hdisp, s_vdisp;
  logic [15:0] s_rgb;

  int n_tot = 0;
  int n_bad = 0;

  lcd_timing_gen #(.REQ_LEAD(1)) u_def (
    .lcd_pclk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid0),
    .cfg_hs(cfg_hs), .cfg_hb(cfg_hb), .cfg_hd(cfg_hd), .cfg_hf(cfg_hf),
    .cfg_vs(cfg_vs), .cfg_vb(cfg_vb), .cfg_vd(cfg_vd), .cfg_vf(cfg_vf),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol),
    .cfg_pending(d_pend), .cfg_err(d_err), .bl_en(bl_en),
    .pixel_data(pix0), .data_req(d_req),
    .pixel_xpos(d_x), .pixel_ypos(d_y),
    .h_disp(d_hdisp), .v_disp(d_vdisp), .frame_start(d_fs),
    .lcd_de(d_de), .lcd_hs(d_hs), .lcd_vs(d_vs), .lcd_rgb(d_rgb),
    .lcd_clk(d_clk), .lcd_bl(d_bl), .lcd_rst(d_rst)
  );

  lcd_timing_gen #(
    .REQ_LEAD(3),
    .DEF_HS(3), .DEF_HB(2), .DEF_HD(8), .DEF_HF(2),
    .DEF_VS(2), .DEF_VB(1), .DEF_VD(4), .DEF_VF(1)
  ) u_dut (
    .lcd_pclk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid),
    .cfg_hs(cfg_hs), .cfg_hb(cfg_hb), .cfg_hd(cfg_hd), .cfg_hf(cfg_hf),
    .cfg_vs(cfg_vs), .cfg_vb(cfg_vb), .cfg_vd(cfg_vd), .cfg_vf(cfg_vf),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol),
    .cfg_pending(s_pend), .cfg_err(s_err), .bl_en(bl_en),
    .pixel_data(pix), .data_req(s_req),
    .pixel_xpos(s_x), .pixel_ypos(s_y),
    .h_disp(s_hdisp), .v_disp(s_vdisp), .frame_start(s_fs),
    .lcd_de(s_de), .lcd_hs(s_hs), .lcd_vs(s_vs), .lcd_rgb(s_rgb),
    .lcd_clk(s_clk), .lcd_bl(s_bl), .lcd_rst(s_rst)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string tag, output int n);
    n = 1;
    tick();
    while (s_fs !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, s_fs, 1);
  endtask

  task automatic send_cfg(input int hs, hb, hd, hf, vs, vb, vd, vf,
                          input logic hp, vp);
    cfg_hs = 11'(hs); cfg_hb = 11'(hb);
    cfg_hd = 11'(hd); cfg_hf = 11'(hf);
    cfg_vs = 11'(vs); cfg_vb = 11'(vb);
    cfg_vd = 11'(vd); cfg_vf = 11'(vf);
    cfg_hpol = hp; cfg_vpol = vp;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // upstream model: answer a request issued in cycle t during cycle t+2
  logic        q1v = 1'b0, q2v = 1'b0;
  logic [10:0] q1x = '0, q2x = '0;
  initial begin
    pix = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      pix = q2v ? 16'hA000 + 16'(q2x) : 16'hDEAD;
      q2v = q1v; q2x = q1x;
      q1v = s_req; q1x = s_x;
    end
  end

  initial begin
    int k, n, m, hp, vp, hb, vb;
    int de_c, hs_c, vs_c, rq_c;
    logic e_req;
    rst_n = 1'b0; bl_en = 1'b1;
    cfg_valid = 1'b0; cfg_valid0 = 1'b0; pix0 = '0;
    cfg_hs = '0; cfg_hb = '0; cfg_hd = '0; cfg_hf = '0;
    cfg_vs = '0; cfg_vb = '0; cfg_vd = '0; cfg_vf = '0;
    cfg_hpol = 1'b0; cfg_vpol = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hs", d_hs, 1);
    chk("rst_vs", d_vs, 1);
    chk("rst_de", d_de, 0);
    chk("rst_lrst", d_rst, 0);
    chk("rst_bl", d_bl, 0);
    chk("rst_fs", d_fs, 0);
    chk("rst_hdisp", d_hdisp, 480);
    chk("rst_vdisp", d_vdisp, 272);
    chk("rst_s_hs", s_hs, 1);
    chk("rst_s_pend", s_pend, 0);
    chk("rst_s_err", s_err, 0);
    chk("rst_s_rgb", s_rgb, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("first_fs", d_fs, 1);
    chk("first_lrst", d_rst, 1);
    chk("first_bl", d_bl, 1);
    chk("first_hs", d_hs, 0);
    chk("first_vs", d_vs, 0);
    chk("lcd_clk", d_clk, 1);

    // 480x272 defaults: request at h=42 line 12, DE one clock after h=43
    k = 1;
    while (!d_req && k < 7000) begin tick(); k++; end
    chk("req_first", k, 6342);
    chk("req_x0", d_x, 0);
    chk("req_y0", d_y, 0);
    while (!d_de && k < 7000) begin tick(); k++; end
    chk("de_first", k, 6344);
    n = 0;
    while (d_de && n < 1000) begin tick(); n++; end
    chk("de_len", n, 480);
    m = 0;
    while (!d_de && m < 1000) begin tick(); m++; end
    chk("line_per", n + m, 525);

    // small timing load on u_dut
    wait_fs("fs0", n);
    repeat (5) tick();
    send_cfg(2, 2, 4, 2, 1, 1, 3, 1, 1'b1, 1'b0);
    chk("ld_pend", s_pend, 1);
    chk("ld_err", s_err, 0);
    chk("ld_hold_hd", s_hdisp, 8);
    wait_fs("fs1", n);
    chk("ap_pend", s_pend, 0);
    chk("ap_hdisp", s_hdisp, 4);
    chk("ap_vdisp", s_vdisp, 3);
    de_c = 0; hs_c = 0; vs_c = 0; rq_c = 0;
    for (int j = 0; j < 60; j++) begin
      hp = j % 10;
      vp = j / 10;
      hb = (j + 1) % 10;
      vb = ((j + 1) / 10) % 6;
      e_req = (vb >= 2) && (vb < 5) && (hb >= 1) && (hb < 5);
      if (s_de) de_c++;
      if (s_hs) hs_c++;
      if (!s_vs) vs_c++;
      if (s_req) rq_c++;
      chk("de", s_de, (vp >= 2 && vp < 5 && hp >= 4 && hp < 8));
      chk("hs", s_hs, (hp < 2));
      chk("vs", s_vs, (vp >= 1));
      chk("req", s_req, e_req);
      chk("xpos", s_x, e_req ? hb - 1 : 0);
      chk("ypos", s_y, e_req ? vb - 2 : 0);
      if (vp >= 2 && vp < 5 && hp >= 4 && hp < 8)
        chk("rgb", s_rgb, 32'hA000 + 32'(hp - 4));
      else
        chk("rgb0", s_rgb, 0);
      tick();
    end
    chk("de_cnt", de_c, 12);
    chk("hs_cnt", hs_c, 12);
    chk("vs_cnt", vs_c, 10);
    chk("req_cnt", rq_c, 12);
    chk("fs_again", s_fs, 1);

    // rejected configs
    repeat (3) tick();
    send_cfg(2, 2, 0, 2, 1, 1, 3, 1, 1'b1, 1'b0);
    chk("rj0_err", s_err, 1);
    chk("rj0_pend", s_pend, 0);
    tick();
    chk("rj0_pulse", s_err, 0);
    send_cfg(600, 500, 500, 500, 1, 1, 3, 1, 1'b1, 1'b0);
    chk("rj1_err", s_err, 1);
    chk("rj1_pend", s_pend, 0);
    tick();
    chk("rj1_pulse", s_err, 0);
    wait_fs("fs2", n);
    chk("rj_hdisp", s_hdisp, 4);
    chk("rj_vdisp", s_vdisp, 3);
    chk("rj_pend", s_pend, 0);

    // A pending, B strobed on the apply cycle (h=9,v=5)
    wait_fs("fs3", n);
    repeat (5) tick();
    send_cfg(2, 2, 6, 2, 1, 1, 2, 1, 1'b0, 1'b1);
    chk("a_pend", s_pend, 1);
    repeat (52) tick();
    send_cfg(3, 1, 5, 1, 1, 1, 4, 1, 1'b1, 1'b0);
    chk("col_pend", s_pend, 1);
    chk("col_hdisp", s_hdisp, 6);
    chk("col_vdisp", s_vdisp, 2);
    wait_fs("fs4", n);
    chk("col_fs_lat", n, 1);
    wait_fs("fs5", n);
    chk("a_frame", n, 60);
    chk("b_pend", s_pend, 0);
    chk("b_hdisp", s_hdisp, 5);
    chk("b_vdisp", s_vdisp, 4);

    // mid-frame reset at v=3
    wait_fs("fs6", n);
    repeat (29) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_hs", s_hs, 1);
    chk("mr_vs", s_vs, 1);
    chk("mr_de", s_de, 0);
    chk("mr_rgb", s_rgb, 0);
    chk("mr_lrst", s_rst, 0);
    chk("mr_bl", s_bl, 0);
    chk("mr_hdisp", s_hdisp, 8);
    chk("mr_d_hdisp", d_hdisp, 480);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rel_lrst0", s_rst, 0);
    tick();
    chk("rel_lrst1", s_rst, 1);
    chk("rel_d_lrst", d_rst, 1);
    chk("rel_fs", s_fs, 1);
    chk("rel_d_hdisp", d_hdisp, 480);
    chk("rel_vdisp", s_vdisp, 4);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
